uart_tx_buffer: RTL

//  Byte FIFO plus drain controller between the UART receive and transmit stages.
//  It captures each received byte on the receiver's valid indication and buffers it.
//  It then feeds bytes one at a time to the transmit module through its tx_flag/done

---
 rtl/uart_tx_buffer_pkg.sv | 19 +
 rtl/uart_tx_buffer_if.sv | 27 ++
 rtl/uart_tx_buffer_fifo.sv | 70 +++++++
 rtl/uart_tx_buffer.sv | 115 +++++++++++
 4 files changed

// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART TX buffer: data width, drain FSM states, timer sizing.
package uart_tx_buffer_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } drain_state_e;

    // Width of a counter that must reach tmo-1; never narrower than one bit.
    function automatic int timer_width(input int tmo);
        return (tmo > 2) ? $clog2(tmo) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Receiver-side, transmitter-side and status signals of the UART TX buffer.
interface uart_tx_buffer_if
    import uart_tx_buffer_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              tx_done;
    logic              ovf_clr;
    logic              tx_flag;
    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              overflow;

    modport master (
        output in_valid, in_data, tx_done, ovf_clr,
        input  tx_flag, tx_data, fifo_count, fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  in_valid, in_data, tx_done, ovf_clr,
        output tx_flag, tx_data, fifo_count, fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/uart_tx_buffer_fifo.sv
// Byte FIFO: circular storage, wrapping pointers and a separate occupancy count.
// Pushes while full and pops while empty are ignored; the caller flags dropped pushes.
module uart_byte_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, full_q;
    logic              wr_en, rd_en;

    assign wr_en = push_i && !full_q;
    assign rd_en = pop_i && !empty_q;

    always_comb begin
        // NOTE: default assigned first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_MAX);
        end
    end

    // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
        if (rd_en) rd_data_q <= mem_q[rd_ptr_q];
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;
    assign empty_o   = empty_q;
    assign full_o    = full_q;
endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers received bytes and feeds them one at a time to the transmitter via tx_flag/tx_done.
// Holds the push edge detector, sticky overflow flag, drain FSM and busy-wait timeout.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter bit EDGE_DET = 1'b1,
    parameter int BUSY_TMO = 8
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    uart_tx_buffer_if.slave bus
);
    localparam int               TMR_W    = timer_width(BUSY_TMO);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TMO - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    drain_state_e      state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              in_valid_q;
    logic              overflow_q, overflow_d;
    logic              tx_flag_q, tx_flag_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              push, pop, load;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty, fifo_full;

    assign push = EDGE_DET ? (bus.in_valid && !in_valid_q) : bus.in_valid;

    uart_byte_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .sys_rst_n   (sys_rst_n),
        .push_i      (push),
        .push_data_i (bus.in_data),
        .pop_i       (pop),
        .rd_data_o   (fifo_rd_data),
        .count_o     (bus.fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // A drop wins over a same-cycle clear so the lost byte is never hidden.
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && bus.tx_done) begin
                    pop     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never signals busy must not stall the buffer.
                if (!bus.tx_done || (timer_q == TMR_LAST)) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_flag_d = (state_d == ST_START);
    assign tx_data_d = load ? fifo_rd_data : tx_data_q;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            in_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            tx_flag_q  <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            in_valid_q <= bus.in_valid;
            overflow_q <= overflow_d;
            tx_flag_q  <= tx_flag_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.tx_flag    = tx_flag_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_full  = fifo_full;
    assign bus.overflow   = overflow_q;
endmodule
